// File: rtl/ecc_apb_ctrl_if.sv
// APB3 bus bundle between a bus master and the ecc_apb_ctrl register front-end.
// Port names follow the AMBA signal names so waveforms line up with the bus protocol.
interface ecc_apb_ctrl_if #(
    parameter int AMBA_WORD       = 32,
    parameter int AMBA_ADDR_WIDTH = 20
);
    logic [AMBA_ADDR_WIDTH-1:0] PADDR;
    logic                       PSEL;
    logic                       PENABLE;
    logic                       PWRITE;
    logic [AMBA_WORD-1:0]       PWDATA;
    logic [AMBA_WORD-1:0]       PRDATA;
    logic                       PREADY;

    modport master (
        output PADDR, PSEL, PENABLE, PWRITE, PWDATA,
        input  PRDATA, PREADY
    );

    modport slave (
        input  PADDR, PSEL, PENABLE, PWRITE, PWDATA,
        output PRDATA, PREADY
    );
endinterface

// File: rtl/ecc_apb_ctrl.sv
// APB3 register front-end and launch/capture sequencer for the Hamming (8,4)/(16,11)/(32,26) encoder.
// Payload is left-aligned into the encoder input; the registered codeword is masked into RESULT.
module ecc_apb_ctrl #(
    parameter int AMBA_WORD       = 32,
    parameter int AMBA_ADDR_WIDTH = 20,
    parameter int DATA_WIDTH      = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    ecc_apb_ctrl_if.slave        apb,
    output logic [AMBA_WORD-1:0] enc_data,
    output logic [1:0]           enc_width,
    output logic                 enc_small,
    output logic                 enc_medium,
    output logic                 enc_large,
    input  logic [AMBA_WORD-1:0] enc_out,
    output logic                 operation_done
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LAUNCH  = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    function automatic logic [AMBA_WORD-1:0] align_payload(input logic [DATA_WIDTH-1:0] d,
                                                           input logic [1:0] w);
        logic [AMBA_WORD-1:0] a;
        a = '0;
        case (w)
            2'd0:    a[AMBA_WORD-1 -: 4]  = d[3:0];
            2'd1:    a[AMBA_WORD-1 -: 11] = d[10:0];
            2'd2:    a[AMBA_WORD-1 -: 26] = d[25:0];
            default: a = '0;
        endcase
        return a;
    endfunction

    function automatic logic [AMBA_WORD-1:0] mask_codeword(input logic [AMBA_WORD-1:0] c,
                                                           input logic [1:0] w);
        logic [AMBA_WORD-1:0] m;
        m = '0;
        case (w)
            2'd0:    m[7:0]  = c[7:0];
            2'd1:    m[15:0] = c[15:0];
            2'd2:    m       = c;
            default: m       = '0;
        endcase
        return m;
    endfunction

    state_t                state_r;
    logic [DATA_WIDTH-1:0] data_r;
    logic [1:0]            width_r;
    logic [AMBA_WORD-1:0]  result_r;
    logic                  done_r;
    logic                  width_err_r;
    logic [AMBA_WORD-1:0]  enc_data_r;
    logic [1:0]            enc_width_r;
    logic                  enc_small_r;
    logic                  enc_medium_r;
    logic                  enc_large_r;
    logic                  op_done_r;

    logic                  wr_s;
    logic                  rd_s;
    logic                  busy_s;
    logic [2:0]            addr_idx_s;
    logic [AMBA_WORD-1:0]  prdata_s;
    logic                  unused_s;

    assign wr_s       = apb.PSEL & apb.PENABLE & apb.PWRITE;
    assign rd_s       = apb.PSEL & apb.PENABLE & ~apb.PWRITE;
    assign busy_s     = (state_r != ST_IDLE);
    assign addr_idx_s = apb.PADDR[4:2];
    assign unused_s   = ^{apb.PADDR[AMBA_ADDR_WIDTH-1:5], apb.PADDR[1:0]};

    // Register file and sequencer; software registers only change while idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= ST_IDLE;
            data_r       <= '0;
            width_r      <= 2'd0;
            result_r     <= '0;
            done_r       <= 1'b0;
            width_err_r  <= 1'b0;
            enc_data_r   <= '0;
            enc_width_r  <= 2'd0;
            enc_small_r  <= 1'b0;
            enc_medium_r <= 1'b0;
            enc_large_r  <= 1'b0;
            op_done_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (wr_s) begin
                        case (addr_idx_s)
                            3'd0: begin
                                if (apb.PWDATA[0]) begin
                                    if (width_r == 2'd3) begin
                                        width_err_r <= 1'b1;
                                    end else begin
                                        state_r      <= ST_LAUNCH;
                                        done_r       <= 1'b0;
                                        width_err_r  <= 1'b0;
                                        enc_data_r   <= align_payload(data_r, width_r);
                                        enc_width_r  <= width_r;
                                        enc_small_r  <= (width_r == 2'd0);
                                        enc_medium_r <= (width_r == 2'd1);
                                        enc_large_r  <= (width_r == 2'd2);
                                    end
                                end
                            end
                            3'd1:    data_r  <= apb.PWDATA[DATA_WIDTH-1:0];
                            3'd2:    width_r <= apb.PWDATA[1:0];
                            default: ;
                        endcase
                    end
                end
                ST_LAUNCH: begin
                    state_r <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    state_r   <= ST_DONE;
                    result_r  <= mask_codeword(enc_out, enc_width_r);
                    done_r    <= 1'b1;
                    op_done_r <= 1'b1;
                end
                ST_DONE: begin
                    state_r      <= ST_IDLE;
                    op_done_r    <= 1'b0;
                    enc_data_r   <= '0;
                    enc_width_r  <= 2'd0;
                    enc_small_r  <= 1'b0;
                    enc_medium_r <= 1'b0;
                    enc_large_r  <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Read mux; the bus sees zero outside a read access phase.
    always_comb begin
        prdata_s = '0;
        if (rd_s) begin
            case (addr_idx_s)
                3'd1:    prdata_s = AMBA_WORD'(data_r);
                3'd2:    prdata_s = AMBA_WORD'(width_r);
                3'd4:    prdata_s = result_r;
                3'd5:    prdata_s = AMBA_WORD'({width_err_r, done_r, busy_s});
                default: prdata_s = '0;
            endcase
        end else begin
            prdata_s = '0;
        end
    end

    assign apb.PRDATA     = prdata_s;
    assign apb.PREADY     = 1'b1;
    assign enc_data       = enc_data_r;
    assign enc_width      = enc_width_r;
    assign enc_small      = enc_small_r;
    assign enc_medium     = enc_medium_r;
    assign enc_large      = enc_large_r;
    assign operation_done = op_done_r;

endmodule
